tetris_line_clear: RTL
======================

Name: tetris_line_clear

Overview:
- Downstream of the falling-piece logic; consumes the settled board after each piece lock.
- Finds full rows, removes them and drops every row above down by one.
- Hands back the compacted board plus lines-cleared and score values.
- Sequential row-by-row scan. Shifts one cleared row per cycle, so there is no wide combinational search over the whole board.

Parameters:
- WIDTH, 10, columns per row.
- HEIGHT, 20, rows per board.
- SCORE_W, 20, score accumulator width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- board_in  input  WIDTH*HEIGHT  board to compact. Cell (x,y) is bit x+y*WIDTH; y=0 is the bottom row.
- board_out  output  WIDTH*HEIGHT  compacted board; updated only in DONE.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse in the DONE state.
- lines_cleared  output  5  rows removed by the last operation; updated in DONE.
- score  output  SCORE_W  accumulated score; saturating.

Behaviour:
- Reset values: state IDLE, row index 0, work register 0, board_out 0, busy 0, done 0, lines_cleared 0, score 0.
- rst in any state, including mid-scan, forces all reset values on the next edge. A partial result is discarded.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - start=1 → work register ← board_in, row index r ← 0, clear count ← 0, go to SCAN.
  - start=0 → stay in IDLE.
- SCAN (row r):
  - Row r all ones → go to SHIFT.
  - Otherwise, r==HEIGHT-1 → go to DONE.
  - Otherwise → r ← r+1, stay in SCAN.
- SHIFT:
  - Rows r..HEIGHT-2 ← rows r+1..HEIGHT-1, and row HEIGHT-1 ← 0.
  - Clear count +1.
  - Return to SCAN with r unchanged, so the row that dropped into r is re-checked.
- DONE:
  - board_out ← work register; lines_cleared ← clear count; done=1.
  - score ← score + weight(count). Weights: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - If the sum exceeds 2^SCORE_W-1, score sticks at all ones.
  - Next state IDLE.
- busy=1 in SCAN, SHIFT and DONE; 0 in IDLE.
- start while busy is ignored: no queueing, no effect on the current operation.
- start in the same cycle as DONE is also ignored. It is accepted only once the block is back in IDLE.
- Latency: start sampled at edge 0 → done high in cycle HEIGHT+1+2k, where k = rows cleared. With defaults: 21 cycles for no clears, 29 for four.
- Clear count is 5 bits and cannot overflow: at most HEIGHT(20) clears.
- A fully-set input board clears all 20 rows → board_out all zero, lines_cleared 20, score +1200.
- board_out, lines_cleared and score hold their values between DONE pulses.

Test Plan:
- Empty board_in, start pulse → done in cycle 21, board_out 0, lines_cleared 0, score 0, busy high for cycles 1–21.
- Row 0 full, plus bit 13 set (x=3,y=1) → done in cycle 23, board_out only bit 3 set, lines_cleared 1, score 40.
- Rows 0–3 full, plus bit 45 set (x=5,y=4) → done in cycle 29, board_out only bit 5 set, lines_cleared 4, score 1200. Then repeat with an empty board → score stays 1200.
- Rows 2 and 5 full, marker bits at (0,3) and (9,6) → markers at (0,2) and (9,4), lines_cleared 2, score +100. Separately, row 19 alone full → row 19 zero in board_out, lines_cleared 1.
- Pulse start again in cycles 5 and 21 of an operation → ignored, exactly one done pulse. Assert rst in cycle 10 of a scan → next cycle busy 0, board_out 0, score 0, no done pulse.
- Preload score near saturation via repeated 4-line clears (or reduced SCORE_W=11) → score clamps at all ones and never wraps.

Source files
------------

// File: rtl/tetris_line_clear_if.sv
// Request/result bundle for the line-clear engine: start/board in, compacted board, status and score out.
interface tetris_line_clear_if #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 20,
  parameter int unsigned SCORE_W = 20
) ();
  logic                      start;
  logic [WIDTH*HEIGHT-1:0]   board_in;
  logic [WIDTH*HEIGHT-1:0]   board_out;
  logic                      busy;
  logic                      done;
  logic [4:0]                lines_cleared;
  logic [SCORE_W-1:0]        score;

  modport master (
    output start, board_in,
    input  board_out, busy, done, lines_cleared, score
  );

  modport slave (
    input  start, board_in,
    output board_out, busy, done, lines_cleared, score
  );
endinterface

// File: rtl/tetris_line_clear.sv
// Row-serial line clear: scans rows bottom-up, removes one full row per SHIFT cycle,
// then publishes the compacted board, clear count and saturating score.
module tetris_line_clear #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 20,
  parameter int unsigned SCORE_W = 20
) (
  input logic               clk,
  input logic               rst,
  tetris_line_clear_if.slave bus
);

  localparam int unsigned CELLS    = WIDTH * HEIGHT;
  localparam int unsigned ROW_W    = $clog2(HEIGHT);
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned WEIGHT_W = 11;
  localparam int unsigned SUM_W    = ((SCORE_W > WEIGHT_W) ? SCORE_W : WEIGHT_W) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic [ROW_W-1:0]   row;
  logic [CELLS-1:0]   work;
  logic [CNT_W-1:0]   count;

  logic               row_full_c;
  logic               last_row_c;
  logic [CELLS-1:0]   shifted_c;
  logic [WEIGHT_W-1:0] weight_c;
  logic [SUM_W-1:0]   sum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic               busy_c;
  logic               done_c;
  logic               publish_c;

  assign row_full_c = &work[32'(row) * WIDTH +: WIDTH];
  assign last_row_c = (row == ROW_W'(HEIGHT - 1));

  // Rows at or above the current row drop by one; the top row always empties.
  always_comb begin
    shifted_c = work;
    for (int unsigned i = 0; i < HEIGHT - 1; i++) begin
      if (i >= 32'(row)) begin
        shifted_c[i*WIDTH +: WIDTH] = work[(i+1)*WIDTH +: WIDTH];
      end
    end
    shifted_c[(HEIGHT-1)*WIDTH +: WIDTH] = '0;
  end

  always_comb begin
    weight_c = '0;
    case (count)
      CNT_W'(0): weight_c = WEIGHT_W'(0);
      CNT_W'(1): weight_c = WEIGHT_W'(40);
      CNT_W'(2): weight_c = WEIGHT_W'(100);
      CNT_W'(3): weight_c = WEIGHT_W'(300);
      default:   weight_c = WEIGHT_W'(1200);
    endcase
  end

  assign sum_c        = SUM_W'(bus.score) + SUM_W'(weight_c);
  assign score_next_c = (sum_c > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : SCORE_W'(sum_c);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SCAN;
      SCAN: begin
        if (row_full_c)      next_state = SHIFT;
        else if (last_row_c) next_state = DONE;
      end
      SHIFT:   next_state = SCAN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode on next state so the registered outputs line up with the state.
  always_comb begin
    busy_c    = 1'b0;
    done_c    = 1'b0;
    publish_c = 1'b0;
    if (next_state != IDLE) busy_c = 1'b1;
    if (next_state == DONE) begin
      done_c    = 1'b1;
      publish_c = 1'b1;
    end
  end

  // Working board, row pointer and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= '0;
      work  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work  <= bus.board_in;
            row   <= '0;
            count <= '0;
          end
        end
        SCAN:    if (!row_full_c && !last_row_c) row <= row + ROW_W'(1);
        SHIFT: begin
          work  <= shifted_c;
          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.board_out     <= '0;
      bus.lines_cleared <= '0;
      bus.score         <= '0;
    end else begin
      bus.busy <= busy_c;
      bus.done <= done_c;
      if (publish_c) begin
        bus.board_out     <= work;
        bus.lines_cleared <= count;
        bus.score         <= score_next_c;
      end
    end
  end

endmodule
